// File: rtl/pit_pkg.sv
// Shared definitions for the programmable interval timer.
//   pit_mode_t       : counting mode held in CTRL[1:0]
//   REG_*            : per-channel register offsets (addr[1:0])
//   CTRL_* / STAT_*  : bit positions inside CTRL and STATUS
//   bcd_dec          : one-step BCD decrement, borrow rippling across nibbles
//   bcd_half         : BCD divide-by-two, used for the SQUARE high/low split
//   mode_out_init    : waveform level a channel shows right after load / mode change
// The BCD helpers are only referenced when PIT_BCD_EN is defined.
package pit_pkg;

  typedef enum logic [1:0] {ONESHOT, RATE, SQUARE, STROBE} pit_mode_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_MODE_LO = 0;
  localparam int unsigned CTRL_MODE_HI = 1;
  localparam int unsigned CTRL_BCD     = 2;
  localparam int unsigned CTRL_EN      = 3;
  localparam int unsigned CTRL_IRQ_EN  = 4;

  localparam int unsigned STAT_OUT     = 0;
  localparam int unsigned STAT_PENDING = 1;
  localparam int unsigned STAT_RUNNING = 2;
  localparam int unsigned STAT_LATCH   = 3;

  // Out-of-range nibbles (A..F) simply decrement as binary for that digit.
  function automatic logic [63:0] bcd_dec(input logic [63:0] value, input int unsigned ndig);
    logic [63:0] res;
    logic        borrow;
    logic [3:0]  d;
    res    = value;
    borrow = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(ndig) && borrow) begin
        d = value[4*i +: 4];
        if (d == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = d - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [63:0] bcd_half(input logic [63:0] value, input int unsigned ndig);
    logic [63:0] res;
    logic        rem;
    logic [4:0]  v;
    res = '0;
    rem = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i < int'(ndig)) begin
        v             = {1'b0, value[4*i +: 4]} + (rem ? 5'd10 : 5'd0);
        res[4*i +: 4] = v[4:1];
        rem           = v[0];
      end
    end
    return res;
  endfunction

  function automatic logic mode_out_init(input pit_mode_t m);
    return m != ONESHOT;
  endfunction

endpackage

// File: rtl/pit_channel.sv
// One timer channel: down-counter, mode sequencing, waveform output, W1C pending flag and
// count latch. Bus strobes arrive already qualified by chip select and channel decode.
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   wr_i, rd_i       : write / read strobe for this channel
//   reg_i            : register offset
//   wdata_i          : write data
//   tick_i, gate_i   : count enable pulse and level gate
//   rdata_o          : combinational read value for reg_i
//   out_o, irq_o     : waveform output, pending & irq_en
// Optional feature: PIT_BCD_EN enables BCD counting selected by CTRL.bcd.
module pit_channel
  import pit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [1:0]       reg_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             tick_i,
  input  logic             gate_i,
  output logic [CNT_W-1:0] rdata_o,
  output logic             out_o,
  output logic             irq_o
);

  localparam int unsigned NDig = CNT_W / 4;

  pit_mode_t        mode_q, mode_d;
  logic             en_q, en_d, irq_en_q, irq_en_d;
  logic [CNT_W-1:0] reload_q, reload_d, count_q, count_d, latch_q, latch_d;
  logic             out_q, out_d, pending_q, pending_d, running_q, running_d;
  logic             latch_vld_q, latch_vld_d, loaded_q, loaded_d;
  logic             bcd_q;

  logic wr_ctrl, wr_reload, wr_status, rd_count, latch_req, step, term, hw_pend;
  logic [CNT_W-1:0] dec_val, half_val;

  assign wr_ctrl   = wr_i && (reg_i == REG_CTRL);
  assign wr_reload = wr_i && (reg_i == REG_RELOAD);
  assign wr_status = wr_i && (reg_i == REG_STATUS);
  assign rd_count  = rd_i && (reg_i == REG_COUNT);
  assign latch_req = wr_status && wdata_i[STAT_LATCH];
  assign step      = tick_i && gate_i && running_q;
  assign term      = (count_q == CNT_W'(1));

`ifdef PIT_BCD_EN
  logic bcd_d;
  assign bcd_d = wr_ctrl ? wdata_i[CTRL_BCD] : bcd_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) bcd_q <= 1'b0;
    else         bcd_q <= bcd_d;
  end
`else
  assign bcd_q = 1'b0;
`endif

  // Reload 0 stands for the full range, so its half is the top-digit midpoint.
  always_comb begin
    dec_val  = count_q - CNT_W'(1);
    half_val = (reload_q == '0) ? (CNT_W'(1) << (CNT_W - 1)) : (reload_q >> 1);
`ifdef PIT_BCD_EN
    if (bcd_q) begin
      dec_val  = CNT_W'(bcd_dec(64'(count_q), NDig));
      half_val = (reload_q == '0) ? (CNT_W'(5) << (CNT_W - 4))
                                  : CNT_W'(bcd_half(64'(reload_q), NDig));
    end
`endif
  end

  always_comb begin
    mode_d      = mode_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    reload_d    = reload_q;
    count_d     = count_q;
    latch_d     = latch_q;
    out_d       = out_q;
    pending_d   = pending_q;
    running_d   = running_q;
    latch_vld_d = latch_vld_q;
    loaded_d    = loaded_q;
    hw_pend     = 1'b0;

    // A reload write swallows any tick in the same cycle.
    if (wr_reload) begin
      reload_d  = wdata_i;
      count_d   = wdata_i;
      running_d = en_q;
      out_d     = mode_out_init(mode_q);
      loaded_d  = 1'b1;
    end else if (step) begin
      unique case (mode_q)
        ONESHOT, STROBE: begin
          count_d = dec_val;
          if (term) begin
            out_d     = (mode_q == ONESHOT);
            hw_pend   = 1'b1;
            running_d = 1'b0;
          end
        end
        RATE: begin
          if (term) begin
            count_d = reload_q;
            out_d   = 1'b1;
            hw_pend = 1'b1;
          end else begin
            count_d = dec_val;
            out_d   = (dec_val != CNT_W'(1));
          end
        end
        SQUARE: begin
          if (term) begin
            count_d = reload_q;
            out_d   = 1'b1;
            hw_pend = 1'b1;
          end else begin
            count_d = dec_val;
            out_d   = (dec_val > half_val);
          end
        end
        default: ;
      endcase
    end else if (mode_q == STROBE && !out_q && !running_q && tick_i && gate_i) begin
      // Strobe pulse lasts exactly one tick after terminal count.
      out_d = 1'b1;
    end

    if (wr_ctrl) begin
      mode_d   = pit_mode_t'(wdata_i[CTRL_MODE_HI:CTRL_MODE_LO]);
      en_d     = wdata_i[CTRL_EN];
      irq_en_d = wdata_i[CTRL_IRQ_EN];
      if (mode_d != mode_q) begin
        running_d = 1'b0;
        out_d     = mode_out_init(mode_d);
      end else if (!wdata_i[CTRL_EN]) begin
        running_d = 1'b0;
      end else if (!en_q && loaded_q) begin
        // Resume from the frozen count; never start on an unloaded counter.
        running_d = 1'b1;
      end
    end

    if (rd_count && !latch_req) latch_vld_d = 1'b0;
    if (wr_status && wdata_i[STAT_PENDING]) pending_d = 1'b0;
    if (latch_req) begin
      latch_d     = count_q;
      latch_vld_d = 1'b1;
    end
    if (hw_pend) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q      <= ONESHOT;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      reload_q    <= '0;
      count_q     <= '0;
      latch_q     <= '0;
      out_q       <= 1'b0;
      pending_q   <= 1'b0;
      running_q   <= 1'b0;
      latch_vld_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      latch_q     <= latch_d;
      out_q       <= out_d;
      pending_q   <= pending_d;
      running_q   <= running_d;
      latch_vld_q <= latch_vld_d;
      loaded_q    <= loaded_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      REG_CTRL: begin
        rdata_o[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
        rdata_o[CTRL_BCD]                  = bcd_q;
        rdata_o[CTRL_EN]                   = en_q;
        rdata_o[CTRL_IRQ_EN]               = irq_en_q;
      end
      REG_RELOAD: rdata_o = '0;
      REG_COUNT:  rdata_o = (latch_vld_q && !latch_req) ? latch_q : count_q;
      REG_STATUS: begin
        rdata_o[STAT_OUT]     = out_q;
        rdata_o[STAT_PENDING] = pending_q;
        rdata_o[STAT_RUNNING] = running_q;
        rdata_o[STAT_LATCH]   = latch_vld_q;
      end
      default: rdata_o = '0;
    endcase
  end

  assign out_o = out_q;
  assign irq_o = pending_q && irq_en_q;

endmodule

// File: rtl/pit_timer.sv
// Multi-channel programmable interval timer: NCH independent down-counters behind a
// register bus. Address = {channel, reg[1:0]}; rdata is registered, one clock after rd & cs.
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   cs_i, rd_i, wr_i : chip select, read and write strobes
//   addr_i, wdata_i  : register address and write data
//   rdata_o          : registered read data, held until the next read
//   tick_i, gate_i   : per-channel count enable pulses and level gates
//   out_o            : per-channel waveform outputs
//   irq_o            : OR of pending & irq_en across channels
// Optional feature: PIT_BCD_EN enables BCD counting (see pit_channel).
module pit_timer
  import pit_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = $clog2(NCH) + 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cs_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [CNT_W-1:0]  wdata_i,
  output logic [CNT_W-1:0]  rdata_o,
  input  logic [NCH-1:0]    tick_i,
  input  logic [NCH-1:0]    gate_i,
  output logic [NCH-1:0]    out_o,
  output logic              irq_o
);

  logic [ADDR_W-1:0] ch_addr;
  logic [CNT_W-1:0]  ch_rdata [NCH];
  logic [NCH-1:0]    ch_irq;
  logic [CNT_W-1:0]  rd_mux, rdata_q, rdata_d;

  assign ch_addr = addr_i >> 2;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = cs_i && (ch_addr == ADDR_W'(i));

    pit_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .wr_i    (wr_i && sel),
      .rd_i    (rd_i && sel),
      .reg_i   (addr_i[1:0]),
      .wdata_i (wdata_i),
      .tick_i  (tick_i[i]),
      .gate_i  (gate_i[i]),
      .rdata_o (ch_rdata[i]),
      .out_o   (out_o[i]),
      .irq_o   (ch_irq[i])
    );
  end

  // Unmapped channels fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_addr == ADDR_W'(i)) rd_mux = ch_rdata[i];
    end
  end

  assign rdata_d = (cs_i && rd_i) ? rd_mux : rdata_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
  assign irq_o   = |ch_irq;

endmodule

// File: tb/tb_pit_timer.sv
// Directed self-checking bench for pit_timer (NCH=4, CNT_W=16). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_pit_timer;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [CNT_W-1:0] wdata = '0;
  logic [CNT_W-1:0] rdata;
  logic [NCH-1:0]   tick = '1, gate = '1;
  logic [NCH-1:0]   out;
  logic             irq;

  int n_vec = 0;
  int n_err = 0;

  pit_timer #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .cs_i    (cs),
    .rd_i    (rd),
    .wr_i    (wr),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .tick_i  (tick),
    .gate_i  (gate),
    .out_o   (out),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int ch, input int r, input logic [CNT_W-1:0] d);
    logic [1:0] c2, r2;
    c2 = ch[1:0];
    r2 = r[1:0];
    cs = 1'b1; wr = 1'b1; addr = {c2, r2}; wdata = d;
    step(1);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [CNT_W-1:0] d);
    logic [1:0] c2, r2;
    c2 = ch[1:0];
    r2 = r[1:0];
    cs = 1'b1; rd = 1'b1; addr = {c2, r2};
    step(1);
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  initial begin
    logic [CNT_W-1:0] d;
    bit rate_out [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    bit rate_irq [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit sq_out [17]  = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    logic [NCH-1:0] out_exp;

    step(3);
    reset = 1'b0;
    step(1);

    // Reset state
    check_eq("rst_out", 32'(out), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    bus_read(0, 3, d);
    check_eq("rst_status0", 32'(d), 32'h0);

    // T1: one-shot, reload 5, tick every clock
    bus_write(0, 0, 16'h0008);
    bus_write(0, 1, 16'd5);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t1_out_low%0d", k), 32'(out[0]), 32'h0);
      step(1);
    end
    check_eq("t1_out_term", 32'(out[0]), 32'h1);
    bus_read(0, 3, d);
    check_eq("t1_status", 32'(d), 32'h3);
    bus_read(0, 2, d);
    check_eq("t1_count", 32'(d), 32'h0);
    check_eq("t1_irq_masked", 32'(irq), 32'h0);
    bus_write(0, 3, 16'h0002);

    // T2: rate generator, reload 4, irq enabled
    bus_write(1, 0, 16'h0019);
    bus_write(1, 1, 16'd4);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t2_out%0d", k), 32'(out[1]), 32'(rate_out[k]));
      check_eq($sformatf("t2_irq%0d", k), 32'(irq), 32'(rate_irq[k]));
      if (k < 7) step(1);
    end
    bus_write(1, 3, 16'h0002);  // coincides with reload: set wins
    check_eq("t5_w1c_vs_set", 32'(irq), 32'h1);
    bus_write(1, 3, 16'h0002);
    check_eq("t2_w1c", 32'(irq), 32'h0);
    check_eq("t2_out_after", 32'(out[1]), 32'h1);
    bus_write(1, 0, 16'h0001);

    // T3: square wave, reload 5 then 6 at the period boundary
    bus_write(2, 0, 16'h000A);
    bus_write(2, 1, 16'd5);
    for (int k = 0; k < 17; k++) begin
      check_eq($sformatf("t3_out%0d", k), 32'(out[2]), 32'(sq_out[k]));
      if (k == 9) bus_write(2, 1, 16'd6);
      else        step(1);
    end
    bus_write(2, 0, 16'h0002);

    // T4: gate hold and count latch
    bus_write(0, 1, 16'd100);
    step(20);
    gate[0] = 1'b0;
    step(4);
    bus_read(0, 2, d);
    check_eq("t4_gate_hold", 32'(d), 32'd80);
    step(5);
    gate[0] = 1'b1;
    step(20);
    bus_write(0, 3, 16'h0008);
    bus_read(0, 3, d);
    check_eq("t4_status_latch", 32'(d), 32'hC);
    step(2);
    bus_read(0, 2, d);
    check_eq("t4_latched", 32'(d), 32'd60);
    bus_read(0, 2, d);
    check_eq("t4_live", 32'(d), 32'd55);

    // T5: reload write coincident with tick; W1C coincident with terminal count
    bus_write(0, 1, 16'd7);
    bus_read(0, 2, d);
    check_eq("t5_reload_wins", 32'(d), 32'd7);
    step(5);
    bus_write(0, 3, 16'h0002);
    bus_read(0, 3, d);
    check_eq("t5_pending_kept", 32'(d), 32'h3);
    bus_write(0, 3, 16'h0002);
    bus_read(0, 3, d);
    check_eq("t5_pending_clr", 32'(d), 32'h1);
    bus_read(0, 1, d);
    check_eq("reload_reads_0", 32'(d), 32'h0);
    bus_read(1, 0, d);
    check_eq("ctrl_readback", 32'(d), 32'h1);
    bus_write(3, 0, 16'h0004);
    bus_read(3, 0, d);
`ifdef PIT_BCD_EN
    check_eq("ctrl_bcd", 32'(d), 32'h4);
`else
    check_eq("ctrl_bcd", 32'(d), 32'h0);
`endif

`ifdef PIT_BCD_EN
    // T6: BCD countdown from 10
    bus_write(3, 0, 16'h000C);
    bus_write(3, 1, 16'h0010);
    bus_read(3, 2, d);
    check_eq("t6_bcd10", 32'(d), 32'h10);
    for (int k = 9; k >= 0; k--) begin
      bus_read(3, 2, d);
      check_eq($sformatf("t6_bcd%0d", k), 32'(d), 32'(k));
    end
    bus_read(3, 3, d);
    check_eq("t6_status", 32'(d), 32'h3);
    out_exp = 4'b1111;
`else
    out_exp = 4'b0111;
`endif

    // Reset asserted mid-count
    bus_write(0, 0, 16'h0018);
    bus_write(0, 1, 16'd3);
    step(3);
    bus_read(0, 3, d);
    check_eq("pre_rst_status", 32'(d), 32'h3);
    check_eq("pre_rst_irq", 32'(irq), 32'h1);
    check_eq("pre_rst_out", 32'(out), 32'(out_exp));
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_out", 32'(out), 32'h0);
    check_eq("mid_rst_irq", 32'(irq), 32'h0);
    check_eq("mid_rst_rdata", 32'(rdata), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1);
    bus_read(1, 2, d);
    check_eq("post_rst_count1", 32'(d), 32'h0);
    bus_read(0, 3, d);
    check_eq("post_rst_status0", 32'(d), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
